adxl362_ascii_line_feed: RTL and testbench
==========================================

# adxl362_ascii_line_feed

Sequential serializer downstream of the ADXL362 readings-to-ASCII converter. It snapshots one pair of 16-character display lines on a load strobe and streams them byte by byte over a valid/ready handshake into the UART transmit path. Either the hexadecimal ("dat") or the decimal ("txt") line pair can be selected. The PMOD CLS path keeps consuming the same lines in parallel; this block only feeds the serial console.

## Interface
Parameters:
- None. Line length is fixed at 16 characters by the package constant.

Ports:
- i_clk_20mhz  input  1  system clock.
- i_rst_20mhz  input  1  asynchronous, active-high reset.
- i_dat_ascii_line1  input  128  hex-format line 1; char 0 in [127:120].
- i_dat_ascii_line2  input  128  hex-format line 2.
- i_txt_ascii_line1  input  128  decimal-format line 1.
- i_txt_ascii_line2  input  128  decimal-format line 2.
- i_sel_txt  input  1  format select, sampled at load: 1 = txt pair, 0 = dat pair.
- i_load  input  1  single-cycle request to capture and send.
- o_tx_data  output  8  byte presented to the UART TX.
- o_tx_valid  output  1  o_tx_data is valid.
- i_tx_ready  input  1  UART TX accepts the byte this cycle.
- o_busy  output  1  a transfer is in progress.
- o_done  output  1  one-cycle pulse after the final byte is accepted.
- o_drop_count  output  8  saturating count of loads rejected while busy.

## Operation
- States:
  - ST_IDLE: waiting for a load.
  - ST_LINE: sending characters of the current line.
  - ST_CR / ST_LF: sending the line terminator (exist only with the macro).
- Registers: 256-bit snapshot, 4-bit char index, 1-bit line index, plus the output registers.
- Load in ST_IDLE:
  - Capture the selected line1/line2 pair into the snapshot.
  - Clear both indices and enter ST_LINE.
- ST_LINE:
  - o_tx_valid = 1; o_tx_data = snapshot byte [line][index], MSB-first (char 0 = bits [127:120]).
  - On accept (valid && ready): increment the index.
  - Accept of index 15 with the macro: go to ST_CR.
  - Accept of index 15 without the macro: go to line 2, or finish if already on line 2.
- ST_CR sends 8'h0D, then ST_LF sends 8'h0A. After LF, go to line 2 with index cleared, or finish.
- Finish:
  - Return to ST_IDLE and pulse o_done for one cycle.
  - Byte count is 36 with the macro, 32 without.
- o_busy = (state != ST_IDLE).
- Load while busy, including the cycle of the final accept:
  - The load is ignored and the snapshot is untouched.
  - o_drop_count increments and saturates at 255.
- Load in the o_done cycle: accepted, because the state is already ST_IDLE.
- Input lines may change freely after capture; only the snapshot is transmitted.
- o_tx_data and o_tx_valid hold stable while valid && !ready. o_tx_valid never deasserts before acceptance.

## Timing
- All outputs are registered. Reset values: o_tx_data = 8'h00, o_tx_valid = 0, o_busy = 0, o_done = 0, o_drop_count = 0, state = ST_IDLE, snapshot = 0.
- Load accepted in cycle n: o_busy = 1 and o_tx_valid = 1 with char 0 in cycle n+1.
- Throughput: one byte per cycle while i_tx_ready stays high. Each accept presents the next byte in the following cycle.
- Minimum transfer length, load to o_done, with ready held high:
  - 37 cycles with the macro.
  - 33 cycles without.
- Final accept in cycle m: o_done = 1 and o_busy = 0 in cycle m+1; o_tx_valid = 0 in m+1.
- Reset asserted mid-transfer:
  - Immediately forces the reset values; no o_done is produced.
  - The partial line is abandoned.

## Configuration
- ADXL362_LINE_FEED_CRLF_EN defined: a CR LF pair (8'h0D, 8'h0A) follows each 16-char line; 36 bytes per transfer.
- Not defined: ST_CR and ST_LF are compiled out; the two lines are sent back to back; 32 bytes per transfer.

## Structure
- Shared package adxl362_ascii_pkg holds:
  - c_line_chars = 16, c_ascii_cr = 8'h0D, c_ascii_lf = 8'h0A.
  - The state enum t_feed_state.
  - The 128-bit line typedef t_ascii_line.
- One natural sub-module, ascii_line_byte_select: combinational 16:1 byte mux from t_ascii_line and the 4-bit index. It is also reusable by the CLS writer.

## Test plan
- dat select, ready held high, line1 "X:0123  Y:ABCD  ", line2 "Z:0001  T:00F0  ", macro on:
  - 36 bytes in order, the 17th = 8'h0D and the 18th = 8'h0A.
  - o_done in cycle 37 after the load.
- txt select with the macro off: 32 bytes exactly matching the txt inputs, no 8'h0D/8'h0A, o_done 33 cycles after the load.
- Backpressure with ready toggling 1-0-0-1: o_tx_data and o_tx_valid stable through the low cycles; no byte lost or duplicated; sequence identical to the ready-high case.
- Load pulses every 10 cycles during a transfer:
  - Only the first load is served; o_drop_count = 3 after the transfer; the transmitted text is the first snapshot even though the inputs changed.
  - 300 dropped loads leave o_drop_count = 255.
- Load in the o_done cycle: a second transfer starts next cycle with char 0. Load on the final-accept cycle: dropped and counted.
- Reset asserted after byte 20: all outputs return to reset values next edge; no o_done; a later load restarts at char 0 of line 1.

Source files
------------

// File: rtl/adxl362_ascii_pkg.sv
// Shared types and constants for the ADXL362 ASCII display/console path.
// ADXL362_LINE_FEED_CRLF_EN adds the CR/LF terminator states to t_feed_state.
package adxl362_ascii_pkg;

  localparam int unsigned c_line_chars = 16;
  localparam logic [7:0]  c_ascii_cr   = 8'h0D;
  localparam logic [7:0]  c_ascii_lf   = 8'h0A;

  typedef logic [8*c_line_chars-1:0] t_ascii_line;

`ifdef ADXL362_LINE_FEED_CRLF_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_CR   = 2'd2,
    ST_LF   = 2'd3
  } t_feed_state;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LINE = 1'b1
  } t_feed_state;
`endif

endpackage

// File: rtl/ascii_line_byte_select.sv
// Combinational 16:1 character mux; char 0 sits in the most significant byte.
module ascii_line_byte_select
  import adxl362_ascii_pkg::*;
(
  input  t_ascii_line i_line,
  input  logic [3:0]  i_index,
  output logic [7:0]  o_byte
);

  always_comb begin
    o_byte = '0;
    for (int unsigned i = 0; i < c_line_chars; i++) begin
      if (i_index == 4'(i)) o_byte = i_line[(c_line_chars - 1 - i) * 8 +: 8];
    end
  end

endmodule

// File: rtl/adxl362_ascii_line_feed.sv
// Snapshots a two-line ASCII display pair on load and streams it to the UART TX.
// Define ADXL362_LINE_FEED_CRLF_EN to append CR LF after each 16-char line.
module adxl362_ascii_line_feed
  import adxl362_ascii_pkg::*;
(
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  input  logic [127:0] i_txt_ascii_line1,
  input  logic [127:0] i_txt_ascii_line2,
  input  logic         i_sel_txt,
  input  logic         i_load,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_busy,
  output logic         o_done,
  output logic [7:0]   o_drop_count
);

  localparam int unsigned c_lw = 8 * c_line_chars;

  t_feed_state         r_state, w_state_nxt;
  logic [2*c_lw-1:0]   r_snap, w_snap_nxt;
  logic [3:0]          r_char, w_char_nxt;
  logic                r_line, w_line_nxt;
  logic [7:0]          r_tx_data, w_tx_data_nxt;
  logic                r_tx_valid, w_tx_valid_nxt;
  logic                r_busy;
  logic                r_done, w_done_nxt;
  logic [7:0]          r_drop, w_drop_nxt;
  logic                w_accept;
  t_ascii_line         w_cur_line;
  logic [7:0]          w_sel_byte;

  assign w_accept = r_tx_valid & i_tx_ready;

  // The byte is selected from the *next* snapshot/indices so the output register
  // already holds the following character in the cycle after each accept.
  assign w_cur_line = w_line_nxt ? w_snap_nxt[c_lw-1:0] : w_snap_nxt[2*c_lw-1:c_lw];

  ascii_line_byte_select u_byte_sel (
    .i_line  (w_cur_line),
    .i_index (w_char_nxt),
    .o_byte  (w_sel_byte)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    w_char_nxt  = r_char;
    w_line_nxt  = r_line;
    w_done_nxt  = 1'b0;
    w_drop_nxt  = r_drop;

    if (i_load && (r_state != ST_IDLE) && (r_drop != 8'hFF)) w_drop_nxt = r_drop + 8'd1;

    unique case (r_state)
      ST_IDLE: begin
        if (i_load) begin
          w_snap_nxt  = i_sel_txt ? {i_txt_ascii_line1, i_txt_ascii_line2}
                                  : {i_dat_ascii_line1, i_dat_ascii_line2};
          w_char_nxt  = '0;
          w_line_nxt  = 1'b0;
          w_state_nxt = ST_LINE;
        end
      end
      ST_LINE: begin
        if (w_accept) begin
          if (r_char == 4'd15) begin
`ifdef ADXL362_LINE_FEED_CRLF_EN
            w_state_nxt = ST_CR;
`else
            if (!r_line) begin
              w_line_nxt = 1'b1;
              w_char_nxt = '0;
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
`endif
          end else begin
            w_char_nxt = r_char + 4'd1;
          end
        end
      end
`ifdef ADXL362_LINE_FEED_CRLF_EN
      ST_CR: begin
        if (w_accept) w_state_nxt = ST_LF;
      end
      ST_LF: begin
        if (w_accept) begin
          if (!r_line) begin
            w_line_nxt  = 1'b1;
            w_char_nxt  = '0;
            w_state_nxt = ST_LINE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_valid_nxt = (w_state_nxt != ST_IDLE);
    w_tx_data_nxt  = r_tx_data;
    unique case (w_state_nxt)
      ST_LINE: w_tx_data_nxt = w_sel_byte;
`ifdef ADXL362_LINE_FEED_CRLF_EN
      ST_CR:   w_tx_data_nxt = c_ascii_cr;
      ST_LF:   w_tx_data_nxt = c_ascii_lf;
`endif
      default: w_tx_data_nxt = r_tx_data;
    endcase
  end

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      r_state    <= ST_IDLE;
      r_snap     <= '0;
      r_char     <= '0;
      r_line     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_snap     <= w_snap_nxt;
      r_char     <= w_char_nxt;
      r_line     <= w_line_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_valid   = r_tx_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_drop_count = r_drop;

endmodule

// File: tb/tb_adxl362_ascii_line_feed.sv
// Directed self-checking bench for adxl362_ascii_line_feed (either CRLF build).
module tb_adxl362_ascii_line_feed;

`ifdef ADXL362_LINE_FEED_CRLF_EN
  localparam int NB = 36;
`else
  localparam int NB = 32;
`endif

  localparam logic [127:0] DAT1 = "X:0123  Y:ABCD  ";
  localparam logic [127:0] DAT2 = "Z:0001  T:00F0  ";
  localparam logic [127:0] TXT1 = "X:+0291 Y:-1234 ";
  localparam logic [127:0] TXT2 = "Z:+1000 T:+0024 ";

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] dat1 = DAT1, dat2 = DAT2, txt1 = TXT1, txt2 = TXT2;
  logic         sel_txt = 1'b0;
  logic         load = 1'b0;
  logic         ready = 1'b1;
  logic [7:0]   tx_data;
  logic         tx_valid, busy, done;
  logic [7:0]   drop_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_b [0:35];

  adxl362_ascii_line_feed dut (
    .i_clk_20mhz       (clk),
    .i_rst_20mhz       (rst),
    .i_dat_ascii_line1 (dat1),
    .i_dat_ascii_line2 (dat2),
    .i_txt_ascii_line1 (txt1),
    .i_txt_ascii_line2 (txt2),
    .i_sel_txt         (sel_txt),
    .i_load            (load),
    .o_tx_data         (tx_data),
    .o_tx_valid        (tx_valid),
    .i_tx_ready        (ready),
    .o_busy            (busy),
    .o_done            (done),
    .o_drop_count      (drop_count)
  );

  always #25 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input logic sel);
    logic [127:0] l [2];
    int n;
    n = 0;
    l[0] = sel ? txt1 : dat1;
    l[1] = sel ? txt2 : dat2;
    for (int li = 0; li < 2; li++) begin
      for (int c = 0; c < 16; c++) begin
        exp_b[n] = l[li][(15 - c) * 8 +: 8];
        n++;
      end
`ifdef ADXL362_LINE_FEED_CRLF_EN
      exp_b[n] = 8'h0D; n++;
      exp_b[n] = 8'h0A; n++;
`endif
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1-0-0-1.
  // drop_period > 0 pulses load (with changed inputs) every drop_period cycles.
  task automatic xfer(input logic sel, input int mode, input int drop_period, input int exp_cycles);
    int cyc, k;
    logic pv, pr, seen_done;
    logic [7:0] pd;
    build_exp(sel);
    sel_txt = sel;
    load = 1'b1;
    step();
    load = 1'b0;
    cyc = 1; k = 0; pv = 1'b0; pr = 1'b1; pd = '0; seen_done = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", tx_valid, 1);
    while (cyc < 400) begin
      if (done) begin seen_done = 1'b1; break; end
      ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (pv && !pr) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
      end
      if (tx_valid && ready) begin
        if (k < NB) chk($sformatf("byte%0d", k), tx_data, exp_b[k]);
        k++;
      end
      pv = tx_valid; pr = ready; pd = tx_data;
      if (drop_period > 0 && (cyc % drop_period) == 0) begin
        load = 1'b1;
        dat1 = ~dat1; dat2 = ~dat2; txt1 = ~txt1; txt2 = ~txt2;
      end else begin
        load = 1'b0;
      end
      step();
      cyc++;
    end
    load = 1'b0;
    ready = 1'b1;
    chk("done_seen", seen_done, 1);
    chk("byte_count", k, NB);
    if (exp_cycles > 0) chk("load_to_done", cyc, exp_cycles);
    chk("done_busy", busy, 0);
    chk("done_valid", tx_valid, 0);
    dat1 = DAT1; dat2 = DAT2; txt1 = TXT1; txt2 = TXT2;
  endtask

  typedef struct {
    logic sel;
    int   mode;
    int   exp_cycles;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0] = '{sel: 1'b0, mode: 0, exp_cycles: NB + 1};
    tbl[1] = '{sel: 1'b1, mode: 0, exp_cycles: NB + 1};
    tbl[2] = '{sel: 1'b0, mode: 1, exp_cycles: 0};
    tbl[3] = '{sel: 1'b1, mode: 1, exp_cycles: 0};

    // reset values
    step(); step();
    chk("rst_data", tx_data, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      xfer(tbl[i].sel, tbl[i].mode, 0, tbl[i].exp_cycles);
      step();
    end
    chk("no_drops_yet", drop_count, 0);

    // loads every 10 cycles while busy: first snapshot only, three drops
    xfer(1'b0, 0, 10, NB + 1);
    chk("drop_3", drop_count, 3);
    step();

    // load in the done cycle is served; load on the final accept is dropped
    begin
      int cyc;
      build_exp(1'b0);
      sel_txt = 1'b0; ready = 1'b1;
      load = 1'b1; step(); load = 1'b0;
      cyc = 1;
      while (!done && cyc < 100) begin step(); cyc++; end
      chk("first_done", done, 1);
      load = 1'b1; step(); load = 1'b0;
      chk("rel_busy", busy, 1);
      chk("rel_valid", tx_valid, 1);
      chk("rel_char0", tx_data, exp_b[0]);
      for (int i = 0; i < NB - 1; i++) step();
      chk("last_byte", tx_data, exp_b[NB-1]);
      load = 1'b1; step(); load = 1'b0;
      chk("fa_done", done, 1);
      chk("fa_busy", busy, 0);
      chk("fa_drop", drop_count, 4);
      step();
      chk("fa_not_served", busy, 0);
    end

    // drop-count saturation under a long stall
    begin
      int cyc;
      build_exp(1'b0);
      sel_txt = 1'b0; ready = 1'b0;
      load = 1'b1; step();
      for (int i = 0; i < 250; i++) step();
      chk("drop_254", drop_count, 254);
      for (int i = 0; i < 50; i++) step();
      chk("drop_sat", drop_count, 255);
      chk("stall_valid", tx_valid, 1);
      chk("stall_data", tx_data, exp_b[0]);
      load = 1'b0; ready = 1'b1;
      cyc = 0;
      while (!done && cyc < 100) begin step(); cyc++; end
      chk("sat_done", done, 1);
      step();
    end

    // asynchronous reset mid-transfer, then a clean restart
    begin
      build_exp(1'b0);
      sel_txt = 1'b0; ready = 1'b1;
      load = 1'b1; step(); load = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("pre_rst_byte20", tx_data, exp_b[20]);
      #10 rst = 1'b1;
      #1;
      chk("mid_rst_valid", tx_valid, 0);
      chk("mid_rst_data", tx_data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_drop", drop_count, 0);
      step();
      chk("mid_rst_done", done, 0);
      rst = 1'b0;
      step();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      xfer(1'b0, 0, 0, NB + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
